// File: rtl/udp_ingress_gearbox.sv
// Packs 64-bit MAC words into 256-bit beats and always emits exactly FRAME_BEATS beats per frame.
// Short frames are zero-padded and long frames are truncated. Define GEARBOX_STATS_EN to add the frame statistics counters.
module udp_ingress_gearbox #(
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 256,
    parameter int FRAME_BEATS = 63
`ifdef GEARBOX_STATS_EN
    ,
    parameter int CNT_WIDTH   = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  In_data,
    input  logic                 In_valid,
    input  logic                 In_last,
    output logic                 In_ready,
    output logic [OUT_WIDTH-1:0] Out_data,
    output logic                 Out_valid,
    output logic                 Out_last,
    input  logic                 Out_ready
`ifdef GEARBOX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] frames_cnt,
    output logic [CNT_WIDTH-1:0] padded_cnt,
    output logic [CNT_WIDTH-1:0] truncated_cnt
`endif
);

    localparam int LANES  = OUT_WIDTH / IN_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int ACC_W  = OUT_WIDTH - IN_WIDTH;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PAD   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ACC_W-1:0]      r_acc;
    logic [LANE_W-1:0]     r_lane;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [OUT_WIDTH-1:0]  r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;

    logic                  w_out_free;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_close;
    logic                  w_final_beat;
    logic [OUT_WIDTH-1:0]  w_base;
    logic [OUT_WIDTH-1:0]  w_beat;
    logic [ACC_W-1:0]      w_acc_wr;
    logic [ACC_W-1:0]      w_acc_next;
    logic [LANE_W-1:0]     w_lane_next;
    logic [BEAT_W-1:0]     w_beat_next;
    logic                  w_load;
    logic [OUT_WIDTH-1:0]  w_load_data;
    logic                  w_load_last;

    assign w_out_free   = !r_out_valid || Out_ready;
    assign w_in_ready   = (r_state == S_DRAIN) || ((r_state == S_FILL) && w_out_free);
    assign w_accept     = In_valid && w_in_ready;
    assign w_close      = (r_state == S_FILL) && w_accept && ((r_lane == LAST_LANE) || In_last);
    assign w_final_beat = (r_beat_cnt == LAST_BEAT);
    // Lanes at or above the current lane are always zero in the accumulator.
    assign w_base       = {{IN_WIDTH{1'b0}}, r_acc};

    // Beat candidate (accumulator plus the incoming word) and accumulator write-back value.
    always_comb begin
        w_beat   = w_base;
        w_acc_wr = r_acc;
        for (int k = 0; k < LANES; k++) begin
            w_beat[k*IN_WIDTH +: IN_WIDTH] = (r_lane == LANE_W'(k)) ? In_data : w_base[k*IN_WIDTH +: IN_WIDTH];
        end
        for (int k = 0; k < LANES - 1; k++) begin
            w_acc_wr[k*IN_WIDTH +: IN_WIDTH] = (r_lane == LANE_W'(k)) ? In_data : r_acc[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, beat load and counter control.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_data  = w_beat;
        w_load_last  = 1'b0;
        w_lane_next  = r_lane;
        w_beat_next  = r_beat_cnt;
        w_acc_next   = r_acc;
        case (r_state)
            S_FILL: begin
                if (w_close) begin
                    w_load      = 1'b1;
                    w_lane_next = {LANE_W{1'b0}};
                    w_acc_next  = {ACC_W{1'b0}};
                    if (w_final_beat) begin
                        w_load_last  = 1'b1;
                        w_beat_next  = {BEAT_W{1'b0}};
                        w_state_next = In_last ? S_FILL : S_DRAIN;
                    end else begin
                        w_beat_next  = r_beat_cnt + BEAT_W'(1);
                        w_state_next = In_last ? S_PAD : S_FILL;
                    end
                end else if (w_accept) begin
                    w_acc_next  = w_acc_wr;
                    w_lane_next = r_lane + LANE_W'(1);
                end else begin
                    w_acc_next  = r_acc;
                end
            end
            S_PAD: begin
                w_load_data = {OUT_WIDTH{1'b0}};
                if (w_out_free) begin
                    w_load = 1'b1;
                    if (w_final_beat) begin
                        w_load_last  = 1'b1;
                        w_beat_next  = {BEAT_W{1'b0}};
                        w_state_next = S_FILL;
                    end else begin
                        w_beat_next  = r_beat_cnt + BEAT_W'(1);
                    end
                end else begin
                    w_load = 1'b0;
                end
            end
            S_DRAIN: begin
                if (w_accept && In_last) begin
                    w_state_next = S_FILL;
                    w_lane_next  = {LANE_W{1'b0}};
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    // Accumulator, lane/beat counters and the single output beat register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= {ACC_W{1'b0}};
            r_lane      <= {LANE_W{1'b0}};
            r_beat_cnt  <= {BEAT_W{1'b0}};
            r_out_data  <= {OUT_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_acc      <= w_acc_next;
            r_lane     <= w_lane_next;
            r_beat_cnt <= w_beat_next;
            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_valid <= 1'b1;
                r_out_last  <= w_load_last;
            end else if (Out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign In_ready  = w_in_ready;
    assign Out_data  = r_out_data;
    assign Out_valid = r_out_valid;
    assign Out_last  = r_out_last;

`ifdef GEARBOX_STATS_EN
    logic                 r_out_pad;
    logic                 r_out_trunc;
    logic [CNT_WIDTH-1:0] r_frames_cnt;
    logic [CNT_WIDTH-1:0] r_padded_cnt;
    logic [CNT_WIDTH-1:0] r_truncated_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Frame kind travels with the Out_last beat so it is counted when that beat is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_pad       <= 1'b0;
            r_out_trunc     <= 1'b0;
            r_frames_cnt    <= {CNT_WIDTH{1'b0}};
            r_padded_cnt    <= {CNT_WIDTH{1'b0}};
            r_truncated_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_load) begin
                r_out_pad   <= w_load_last && (r_state == S_PAD);
                r_out_trunc <= w_load_last && (r_state == S_FILL) && !In_last;
            end
            if (r_out_valid && Out_ready && r_out_last) begin
                r_frames_cnt <= sat_inc(r_frames_cnt);
                if (r_out_pad) begin
                    r_padded_cnt <= sat_inc(r_padded_cnt);
                end
                if (r_out_trunc) begin
                    r_truncated_cnt <= sat_inc(r_truncated_cnt);
                end
            end
        end
    end

    assign frames_cnt    = r_frames_cnt;
    assign padded_cnt    = r_padded_cnt;
    assign truncated_cnt = r_truncated_cnt;
`endif

endmodule

// File: tb/tb_udp_ingress_gearbox.sv
// Directed self-checking bench for udp_ingress_gearbox: exact, short, long, backpressure and mid-frame reset cases.
// Statistics counters are checked when GEARBOX_STATS_EN is defined.
module tb_udp_ingress_gearbox;

    localparam int NB  = 63;
    localparam int WPF = NB * 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  In_data;
    logic         In_valid;
    logic         In_last;
    logic         In_ready;
    logic [255:0] Out_data;
    logic         Out_valid;
    logic         Out_last;
    logic         Out_ready;
`ifdef GEARBOX_STATS_EN
    logic [15:0]  frames_cnt;
    logic [15:0]  padded_cnt;
    logic [15:0]  truncated_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [256:0] q_beats[$];

    udp_ingress_gearbox dut (
        .clk       (clk),
        .reset     (reset),
        .In_data   (In_data),
        .In_valid  (In_valid),
        .In_last   (In_last),
        .In_ready  (In_ready),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_last  (Out_last),
        .Out_ready (Out_ready)
`ifdef GEARBOX_STATS_EN
        ,
        .frames_cnt    (frames_cnt),
        .padded_cnt    (padded_cnt),
        .truncated_cnt (truncated_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Record every beat that the handshake will transfer at the coming rising edge.
    always @(negedge clk) begin
        if (!reset && Out_valid && Out_ready) begin
            q_beats.push_back({Out_last, Out_data});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beat k of a frame of n words starting at value start: {last, data}.
    function automatic logic [256:0] exp_beat(input int start, input int n, input int k);
        logic [255:0] d;
        int idx;
        d = 256'd0;
        for (int l = 0; l < 4; l++) begin
            idx = 4 * k + l;
            if (idx < n && idx < WPF) begin
                d[l*64 +: 64] = 64'(start + idx);
            end
        end
        return {(k == NB - 1), d};
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last, output int stalls);
        In_data  = d;
        In_valid = 1'b1;
        In_last  = last;
        stalls   = 0;
        @(negedge clk);
        while (!In_ready && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 500) begin
            check_eq("in_ready_timeout", 264'(stalls), 264'(0));
        end
        @(posedge clk);
        #1;
        In_valid = 1'b0;
        In_last  = 1'b0;
    endtask

    task automatic send_frame(input int start, input int n, input logic with_last, output int stalls_total);
        int st;
        stalls_total = 0;
        for (int i = 0; i < n; i++) begin
            send_word(64'(start + i), with_last && (i == n - 1), st);
            stalls_total += st;
        end
    endtask

    task automatic wait_frame(input int base, input string tag);
        int cyc;
        cyc = 0;
        while (q_beats.size() < base + NB && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq($sformatf("%s_beat_count", tag), 264'(q_beats.size() - base), 264'(NB));
    endtask

    task automatic verify_frame(input int base, input int start, input int n, input string tag);
        logic [256:0] obs;
        for (int k = 0; k < NB; k++) begin
            obs = (base + k < q_beats.size()) ? q_beats[base + k] : {257{1'b1}};
            check_eq($sformatf("%s_beat%0d", tag, k), 264'(obs), 264'(exp_beat(start, n, k)));
        end
    endtask

    initial begin
        int base;
        int st;
        logic [256:0] m;

        reset     = 1'b1;
        In_data   = 64'd0;
        In_valid  = 1'b0;
        In_last   = 1'b0;
        Out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 264'(Out_valid), 264'(0));
        check_eq("rst_out_last", 264'(Out_last), 264'(0));
        check_eq("rst_out_data", 264'(Out_data), 264'(0));
        check_eq("rst_in_ready", 264'(In_ready), 264'(1));
`ifdef GEARBOX_STATS_EN
        check_eq("rst_stats", 264'({frames_cnt, padded_cnt, truncated_cnt}), 264'(0));
`endif
        @(posedge clk);
        #1;

        // Exact-length frame
        base = q_beats.size();
        send_frame(0, WPF, 1'b1, st);
        check_eq("exact_in_ready_drops", 264'(st), 264'(0));
        wait_frame(base, "exact");
        verify_frame(base, 0, WPF, "exact");
        check_eq("exact_beat0", 264'(q_beats[base]), 264'({1'b0, 64'd3, 64'd2, 64'd1, 64'd0}));

        // Short frame, padded
        base = q_beats.size();
        send_frame(0, 10, 1'b1, st);
        @(negedge clk);
        check_eq("pad_in_ready", 264'(In_ready), 264'(0));
        wait_frame(base, "short");
        verify_frame(base, 0, 10, "short");
        check_eq("short_beat2", 264'(q_beats[base + 2]), 264'({1'b0, 64'd0, 64'd0, 64'd9, 64'd8}));
        check_eq("short_in_ready_after", 264'(In_ready), 264'(1));

        // Long frame, truncated; drain must accept while the output is stalled
        base = q_beats.size();
        send_frame(2000, WPF, 1'b0, st);
        Out_ready = 1'b0;
        @(negedge clk);
        check_eq("drain_held_last", 264'({Out_valid, Out_last}), 264'(2'b11));
        @(posedge clk);
        #1;
        send_frame(2000 + WPF, 8, 1'b1, st);
        check_eq("drain_in_ready", 264'(st), 264'(0));
        Out_ready = 1'b1;
        wait_frame(base, "long");
        verify_frame(base, 2000, 260, "long");

        // Frame following a truncated one starts at lane 0
        base = q_beats.size();
        send_frame(3000, WPF, 1'b1, st);
        wait_frame(base, "after_long");
        verify_frame(base, 3000, WPF, "after_long");
        check_eq("after_long_lane0", 264'(q_beats[base][63:0]), 264'(64'd3000));

        // Backpressure at beat 10
        base = q_beats.size();
        m = exp_beat(4000, WPF, 10);
        fork
            begin
                send_frame(4000, WPF, 1'b1, st);
            end
            begin
                int cyc;
                cyc = 0;
                while (!(q_beats.size() == base + 10 && Out_valid) && cyc < 3000) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                check_eq("bp_reach_beat10", 264'(q_beats.size() - base), 264'(10));
                Out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check_eq($sformatf("bp_hold%0d", c), 264'({Out_last, Out_valid, Out_data}),
                             264'({m[256], 1'b1, m[255:0]}));
                    check_eq($sformatf("bp_in_ready%0d", c), 264'(In_ready), 264'(0));
                end
                @(posedge clk);
                #1;
                Out_ready = 1'b1;
            end
        join
        wait_frame(base, "bp");
        verify_frame(base, 4000, WPF, "bp");

        // Reset mid-frame, then a fresh frame
        send_frame(5000, 100, 1'b0, st);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 264'(Out_valid), 264'(0));
        check_eq("midrst_in_ready", 264'(In_ready), 264'(1));
`ifdef GEARBOX_STATS_EN
        check_eq("midrst_stats", 264'({frames_cnt, padded_cnt, truncated_cnt}), 264'(0));
`endif
        @(posedge clk);
        #1;
        base = q_beats.size();
        send_frame(6000, WPF, 1'b1, st);
        wait_frame(base, "fresh");
        verify_frame(base, 6000, WPF, "fresh");

        // One short and one long frame after the fresh exact frame
        base = q_beats.size();
        send_frame(7000, 10, 1'b1, st);
        wait_frame(base, "short2");
        verify_frame(base, 7000, 10, "short2");
        base = q_beats.size();
        send_frame(8000, 260, 1'b1, st);
        wait_frame(base, "long2");
        verify_frame(base, 8000, 260, "long2");
`ifdef GEARBOX_STATS_EN
        check_eq("stats_frames", 264'(frames_cnt), 264'(3));
        check_eq("stats_padded", 264'(padded_cnt), 264'(1));
        check_eq("stats_truncated", 264'(truncated_cnt), 264'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
